// File: rtl/mult_job_sequencer_pkg.sv
`default_nettype none
// =====================================================================
// Module  : mult_job_sequencer_pkg
// Brief   : Shared state encoding and default sizes for the job sequencer
// Revision: 1.0
// =====================================================================
package mult_job_sequencer_pkg;

    localparam int c_def_w     = 8;
    localparam int c_def_depth = 4;
    localparam int c_def_cnt_w = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // One extra pointer bit distinguishes full from empty when addresses match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_job_sequencer_job_fifo.sv
`default_nettype none
// =====================================================================
// Module  : job_fifo
// Brief   : Synchronous request FIFO holding packed operand pairs
// Revision: 1.0
// =====================================================================
module job_fifo
    import mult_job_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_ptr_w  = ptr_width(DEPTH);
    localparam int c_addr_w = c_ptr_w - 1;

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               w_full;
    logic               w_empty;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    // Storage is cleared too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push && !w_full) begin
                r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_din;
                r_wr_ptr                      <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !w_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/mult_job_sequencer.sv
`default_nettype none
// =====================================================================
// Module  : mult_job_sequencer
// Brief   : Queues operand pairs and issues one multiplier job at a time
// Revision: 1.0
// =====================================================================
module mult_job_sequencer
    import mult_job_sequencer_pkg::*;
#(
    parameter int W     = c_def_w,
    parameter int DEPTH = c_def_depth,
    parameter int CNT_W = c_def_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_a,
    input  logic [W-1:0]     s_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2*W-1:0]   m_product,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_product,
    output logic             busy,
    output logic [CNT_W-1:0] jobs_done
);

    seq_state_t         r_state;
    logic               r_rst_done;
    logic               r_mul_start;
    logic               r_m_valid;
    logic [2*W-1:0]     r_m_product;
    logic [CNT_W-1:0]   r_jobs_done;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_capture;
    logic [2*W-1:0]     w_head;

    // s_ready stays low until the first clock edge after reset release.
    assign s_ready   = r_rst_done && !w_full;
    assign w_push    = s_valid && s_ready;
    assign w_capture = (r_state == WAIT) && mul_done;

    job_fifo #(
        .DATA_W (2*W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_capture),
        .i_din   ({s_a, s_b}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rst_done  <= 1'b0;
            r_mul_start <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_product <= '0;
            r_jobs_done <= '0;
        end else begin
            r_rst_done  <= 1'b1;
            r_mul_start <= 1'b0;
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                // Registered m_valid gates the start, so a result taken this
                // cycle still defers the next job by one cycle.
                IDLE: begin
                    if (!w_empty && !r_m_valid) begin
                        r_state     <= START;
                        r_mul_start <= 1'b1;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        r_m_product <= mul_product;
                        r_m_valid   <= 1'b1;
                        r_jobs_done <= r_jobs_done + 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mul_a     = w_head[2*W-1:W];
    assign mul_b     = w_head[W-1:0];
    assign mul_start = r_mul_start;
    assign m_valid   = r_m_valid;
    assign m_product = r_m_product;
    assign jobs_done = r_jobs_done;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module  : tb_mult_job_sequencer
// Brief   : Self-checking bench with a behavioural multiplier-core model
// Revision: 1.0
// =====================================================================
module tb_mult_job_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [W-1:0]     s_a = '0;
    logic [W-1:0]     s_b = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [2*W-1:0]   m_product;
    logic             mul_start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_done = 1'b0;
    logic [2*W-1:0]   mul_product = '0;
    logic             busy;
    logic [CNT_W-1:0] jobs_done;

    mult_job_sequencer #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_a         (s_a),
        .s_b         (s_b),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_product   (m_product),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy),
        .jobs_done   (jobs_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: products in request order and completed-job count.
    logic [2*W-1:0] exp_q[$];
    int             model_jobs = 0;

    // Core model: answers each start after a delay with the product of the
    // operands it sees at done time, plus optional spurious done pulses.
    int core_delay = 3;
    bit core_stall = 1'b0;
    bit core_rand  = 1'b0;
    int spur_idle_req = 0, spur_idle_served = 0;
    int spur_start_req = 0, spur_start_served = 0;
    bit core_pending = 1'b0;
    int core_cnt = 0;
    int done_cyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            core_pending = 1'b0;
            mul_done     = 1'b0;
        end else begin
            mul_done = 1'b0;
            if (mul_start) begin
                core_pending = 1'b1;
                core_cnt = core_rand ? int'($urandom_range(6, 1)) : core_delay;
                if (spur_start_req != spur_start_served) begin
                    spur_start_served++;
                    mul_done    = 1'b1;
                    mul_product = 16'hDEAD;
                end
            end else if (core_pending) begin
                if (core_cnt > 0) core_cnt--;
                if (core_cnt == 0 && !core_stall) begin
                    mul_done     = 1'b1;
                    mul_product  = 16'(mul_a) * 16'(mul_b);
                    core_pending = 1'b0;
                    done_cyc     = cyc;
                end
            end else if (spur_idle_req != spur_idle_served) begin
                spur_idle_served++;
                mul_done    = 1'b1;
                mul_product = 16'hBEEF;
            end
        end
    end

    // Output monitor.
    logic [2*W-1:0] got_q[$];
    int got_base = 0;
    int start_cnt = 0;
    int last_start_cyc = -1;
    int valid_rise_cyc = -1;
    bit prev_mv = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mv = 1'b0;
        end else begin
            if (mul_start) begin
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (m_valid && !prev_mv) valid_rise_cyc = cyc;
            prev_mv = m_valid;
            if (m_valid && m_ready) got_q.push_back(m_product);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        while (!s_ready && n < 300) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout s_ready=%0b required 1", s_ready);
            s_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            tick();
            s_valid = 1'b0;
            exp_q.push_back(16'(a) * 16'(b));
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_start(input int prev);
        int n;
        n = 0;
        while (start_cnt <= prev && n < 300) begin
            tick();
            n++;
        end
        if (start_cnt <= prev) begin
            checks++;
            errors++;
            $display("FAIL start_timeout starts=%0d required >%0d", start_cnt, prev);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!m_valid && n < 300) begin
            tick();
            n++;
        end
        if (!m_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout m_valid=%0b required 1", m_valid);
        end
    endtask

    task automatic drain_and_check(input string name);
        int n;
        m_ready = 1'b1;
        while (exp_q.size() > 0) begin
            n = 0;
            while (got_q.size() <= got_base && n < 500) begin
                tick();
                n++;
            end
            checks++;
            if (got_q.size() <= got_base) begin
                errors++;
                $display("FAIL %s result_timeout got none required %0h", name, exp_q[0]);
                exp_q.delete();
            end else begin
                if (got_q[got_base] !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s product got %0h required %0h", name, got_q[got_base], exp_q[0]);
                end
                got_base++;
                model_jobs++;
                void'(exp_q.pop_front());
            end
        end
        tick();
        checks++;
        if (jobs_done !== CNT_W'(model_jobs)) begin
            errors++;
            $display("FAIL %s jobs_done got %0d required %0d", name, jobs_done, CNT_W'(model_jobs));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        checks++;
        if ({s_ready, m_valid, mul_start, busy} !== 4'b0000 || m_product !== '0 || jobs_done !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b mv=%0b st=%0b busy=%0b prod=%0h jd=%0d required all 0",
                     s_ready, m_valid, mul_start, busy, m_product, jobs_done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b required 1", s_ready);
        end
    endtask

    task automatic test_single_job();
        int s0, ca;
        core_delay = 20;
        m_ready = 1'b0;
        s0 = start_cnt;
        push(8'd13, 8'd11, ca);
        wait_start(s0);
        checks++;
        if (last_start_cyc != ca + 1) begin
            errors++;
            $display("FAIL single_start_latency got cyc %0d required %0d", last_start_cyc, ca + 1);
        end
        wait_valid();
        tick();
        checks++;
        if (start_cnt != s0 + 1) begin
            errors++;
            $display("FAIL single_start_count got %0d required %0d", start_cnt - s0, 1);
        end
        checks++;
        if (valid_rise_cyc != done_cyc + 1) begin
            errors++;
            $display("FAIL single_valid_latency got cyc %0d required %0d", valid_rise_cyc, done_cyc + 1);
        end
        checks++;
        if (m_product !== 16'd143 || jobs_done !== 4'd1 || busy !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_result got prod=%0d jd=%0d busy=%0b mv=%0b required 143 1 0 1",
                     m_product, jobs_done, busy, m_valid);
        end
        drain_and_check("single");
    endtask

    task automatic test_fifo_fill();
        int ca, n;
        bit hold_ok;
        m_ready = 1'b1;
        core_delay = 2;
        core_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(W'($urandom), W'($urandom), ca);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_ready got %0b required 0", s_ready);
        end
        s_valid = 1'b1;
        s_a = W'($urandom);
        s_b = W'($urandom);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_ready !== 1'b0) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL fill_hold_ready got 1 required 0");
        end
        core_stall = 1'b0;
        n = 0;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL fill_fifth_accept got s_ready=0 required 1");
            s_valid = 1'b0;
        end else begin
            tick();
            s_valid = 1'b0;
            exp_q.push_back(16'(s_a) * 16'(s_b));
        end
        drain_and_check("fill");
    endtask

    task automatic test_backpressure();
        int ca, s0, r;
        m_ready = 1'b0;
        core_delay = 3;
        for (int i = 0; i < 3; i++) begin
            push(W'($urandom), W'($urandom), ca);
        end
        wait_valid();
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (start_cnt != s0 || busy !== 1'b0 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_start got starts=%0d busy=%0b mv=%0b required 0 0 1",
                     start_cnt - s0, busy, m_valid);
        end
        m_ready = 1'b1;
        r = cyc;
        wait_start(s0);
        checks++;
        if (last_start_cyc != r + 2) begin
            errors++;
            $display("FAIL bp_restart_latency got cyc %0d required %0d", last_start_cyc, r + 2);
        end
        drain_and_check("backpressure");
    endtask

    task automatic test_back_to_back();
        int ca, s0;
        m_ready = 1'b1;
        core_delay = 3;
        s0 = start_cnt;
        push(W'($urandom), W'($urandom), ca);
        push(W'($urandom), W'($urandom), ca);
        wait_start(s0 + 1);
        checks++;
        if (last_start_cyc != done_cyc + 3) begin
            errors++;
            $display("FAIL b2b_restart got cyc %0d required %0d", last_start_cyc, done_cyc + 3);
        end
        drain_and_check("back_to_back");
    endtask

    task automatic test_spurious_done();
        int ca, jd;
        m_ready = 1'b0;
        core_delay = 4;
        push(W'($urandom), W'($urandom), ca);
        push(W'($urandom), W'($urandom), ca);
        wait_valid();
        jd = int'(jobs_done);
        spur_idle_req++;
        spur_start_req++;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (m_valid !== 1'b1 || m_product !== exp_q[0] || int'(jobs_done) != jd) begin
            errors++;
            $display("FAIL spur_idle got mv=%0b prod=%0h jd=%0d required 1 %0h %0d",
                     m_valid, m_product, jobs_done, exp_q[0], jd);
        end
        drain_and_check("spurious");
    endtask

    task automatic test_reset_mid_job();
        int ca, s0;
        m_ready = 1'b1;
        core_delay = 2;
        core_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(W'($urandom_range(255, 1)), W'($urandom_range(255, 1)), ca);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy got %0b required 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, mul_start, busy} !== 4'b0000 || m_product !== '0 ||
            jobs_done !== '0 || mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got rdy=%0b mv=%0b st=%0b busy=%0b prod=%0h jd=%0d a=%0h b=%0h required all 0",
                     s_ready, m_valid, mul_start, busy, m_product, jobs_done, mul_a, mul_b);
        end
        core_stall = 1'b0;
        exp_q.delete();
        got_base = got_q.size();
        model_jobs = 0;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        s0 = start_cnt;
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %0b required 1", s_ready);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (start_cnt != s0 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle got starts=%0d busy=%0b mv=%0b required 0 0 0",
                     start_cnt - s0, busy, m_valid);
        end
    endtask

    task automatic test_counter_wrap();
        core_rand = 1'b1;
        fork
            begin
                int ca;
                for (int i = 0; i < 17; i++) begin
                    push(W'($urandom), W'($urandom), ca);
                end
            end
            begin
                for (int k = 0; k < 3000 && got_q.size() < got_base + 17; k++) begin
                    m_ready = 1'($urandom_range(1, 0));
                    tick();
                end
                m_ready = 1'b1;
            end
        join
        drain_and_check("counter_wrap");
        checks++;
        if (model_jobs != 17 || jobs_done !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count got jd=%0d jobs=%0d required 1 17", jobs_done, model_jobs);
        end
        core_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_fifo_fill();
        test_backpressure();
        test_back_to_back();
        test_spurious_done();
        test_reset_mid_job();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
